dac_setpoint_seq: RTL and testbench

Sequential DAC output stage for the SPGD loop: the output-direction counterpart to the ADC sampling path. It accepts a signed 16Q48 voltage setpoint over a valid/ready handshake and converts it to a 14-bit DAC code in a 3-stage pipeline. It then slews the driven code toward that target at a programmable rate and pulses DONE on arrival. Its output feeds the DACB code lane in place of the combinational voltage-to-code path.

---
 rtl/dac_setpoint_seq_if.sv | 21 ++
 rtl/dac_setpoint_seq.sv | 168 ++++++++++++++++
 tb/tb_dac_setpoint_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_setpoint_seq_if.sv
// Setpoint handshake bundle: signed 16Q48 voltage plus valid/ready.
// master drives data/valid, slave returns ready.
interface dac_setpoint_seq_if #(
  parameter int FLOAT_WIDTH = 64
);
  logic [FLOAT_WIDTH-1:0] ADC_VOLTAGE_IN;
  logic                   IN_VALID;
  logic                   IN_READY;

  modport master (
    output ADC_VOLTAGE_IN,
    output IN_VALID,
    input  IN_READY
  );

  modport slave (
    input  ADC_VOLTAGE_IN,
    input  IN_VALID,
    output IN_READY
  );
endinterface

// File: rtl/dac_setpoint_seq.sv
// DAC setpoint sequencer: 3-cycle voltage-to-code conversion, then a
// rate-limited slew of DAC_CODE_OUT to the target with a DONE pulse.
// Ports: ADC_CLK, rst (sync, active-high), sp (setpoint handshake),
//   SLEW_STEP/TICK_DIV (ramp config), DAC_CODE_OUT, BUSY, DONE, CLAMPED.
module dac_setpoint_seq #(
  parameter int                     FLOAT_WIDTH = 64,
  parameter int                     DAC_WIDTH   = 14,
  parameter logic [FLOAT_WIDTH-1:0] OFFSET      = 64'h000A_0000_0000_0000,
  parameter logic [FLOAT_WIDTH-1:0] SCALE       = 64'h0333_2666_6666_6666,
  parameter logic [DAC_WIDTH-1:0]   RESET_CODE  = 14'd8191
) (
  input  logic                 ADC_CLK,
  input  logic                 rst,
  dac_setpoint_seq_if.slave    sp,
  input  logic [DAC_WIDTH-1:0] SLEW_STEP,
  input  logic [15:0]          TICK_DIV,
  output logic [DAC_WIDTH-1:0] DAC_CODE_OUT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 CLAMPED
);

  localparam int FW   = FLOAT_WIDTH;
  localparam int SW   = FW + 1;
  localparam int PW   = 2 * FW + 1;
  localparam int FRAC = FW - 16;

  localparam logic [PW-1:0] CODE_MAX_P =
    {{(PW-DAC_WIDTH){1'b0}}, {DAC_WIDTH{1'b1}}};
  localparam logic [DAC_WIDTH-1:0] CODE_MAX = {DAC_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    RAMP
  } state_t;

  state_t state_q, state_d;

  logic [FW-1:0]        vin_q;
  logic [SW-1:0]        sum_q;
  logic [PW-1:0]        prod_q;
  logic [1:0]           conv_cnt_q;
  logic [DAC_WIDTH-1:0] target_q;
  logic [DAC_WIDTH-1:0] step_q;
  logic [15:0]          div_q;
  logic [15:0]          tick_q;
  logic [DAC_WIDTH-1:0] code_q;
  logic                 done_q;
  logic                 clamped_q;

  logic                 accept;
  logic                 conv_last;
  logic                 at_target;
  logic                 tick;
  logic [SW-1:0]        sum_d;
  logic [PW-1:0]        prod_d;
  logic [PW-1:0]        prod_int;
  logic [DAC_WIDTH-1:0] target_d;
  logic                 clamp_d;
  logic                 up;
  logic [DAC_WIDTH-1:0] diff;
  logic [DAC_WIDTH-1:0] toward;

  assign sp.IN_READY  = (state_q == IDLE);
  assign BUSY         = (state_q != IDLE);
  assign DAC_CODE_OUT = code_q;
  assign DONE         = done_q;
  assign CLAMPED      = clamped_q;

  assign accept    = (state_q == IDLE) && sp.IN_VALID;
  assign conv_last = (conv_cnt_q == 2'd2);
  assign at_target = (code_q == target_q);
  assign tick      = (tick_q == div_q);

  // Both operands widened to the product width, so the modular
  // product equals the signed product.
  assign sum_d  = {vin_q[FW-1], vin_q} + {1'b0, OFFSET};
  assign prod_d = {{(PW-SW){sum_q[SW-1]}}, sum_q}
                * {{(PW-FW){1'b0}}, SCALE};

  assign prod_int = prod_q >> (2 * FRAC);

  always_comb begin
    target_d = prod_int[DAC_WIDTH-1:0];
    clamp_d  = 1'b0;
    if (sum_q[SW-1]) begin
      target_d = '0;
      clamp_d  = 1'b1;
    end else if (prod_int > CODE_MAX_P) begin
      target_d = CODE_MAX;
      clamp_d  = 1'b1;
    end
  end

  // Step toward target, landing exactly on it when within one step.
  always_comb begin
    up     = (target_q > code_q);
    diff   = up ? (target_q - code_q) : (code_q - target_q);
    toward = target_q;
    if (diff > step_q) begin
      toward = up ? (code_q + step_q) : (code_q - step_q);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (sp.IN_VALID) state_d = CONV;
      CONV: if (conv_last) state_d = RAMP;
      RAMP: if (at_target) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ADC_CLK) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge ADC_CLK) begin
    if (rst) begin
      vin_q      <= '0;
      sum_q      <= '0;
      prod_q     <= '0;
      conv_cnt_q <= '0;
      target_q   <= '0;
      step_q     <= '0;
      div_q      <= '0;
      tick_q     <= '0;
      code_q     <= RESET_CODE;
      done_q     <= 1'b0;
      clamped_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        vin_q      <= sp.ADC_VOLTAGE_IN;
        step_q     <= SLEW_STEP;
        div_q      <= TICK_DIV;
        conv_cnt_q <= '0;
        clamped_q  <= 1'b0;
      end
      if (state_q == CONV) begin
        sum_q      <= sum_d;
        prod_q     <= prod_d;
        conv_cnt_q <= conv_cnt_q + 2'd1;
        if (conv_last) begin
          target_q  <= target_d;
          clamped_q <= clamp_d;
          tick_q    <= '0;
        end
      end
      if (state_q == RAMP) begin
        if (at_target) begin
          done_q <= 1'b1;
        end else if (step_q == '0) begin
          code_q <= target_q;
        end else if (tick) begin
          tick_q <= '0;
          code_q <= toward;
        end else begin
          tick_q <= tick_q + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_setpoint_seq.sv
// Testbench for dac_setpoint_seq: directed setpoints, expected code
// changes and DONE pulses queued and matched by a negedge monitor.
module tb_dac_setpoint_seq;

  localparam logic [63:0] V_P5  = 64'h0005_0000_0000_0000;
  localparam logic [63:0] V_M5  = 64'hFFFB_0000_0000_0000;
  localparam logic [63:0] V_P11 = 64'h000B_0000_0000_0000;
  localparam logic [63:0] V_M12 = 64'hFFF4_0000_0000_0000;
  localparam logic [63:0] V_0   = 64'h0000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] slew_step = '0;
  logic [15:0] tick_div = '0;
  logic [13:0] code;
  logic        busy;
  logic        done;
  logic        clamped;

  dac_setpoint_seq_if sp ();

  always #5 clk = ~clk;

  dac_setpoint_seq dut (
    .ADC_CLK      (clk),
    .rst          (rst),
    .sp           (sp),
    .SLEW_STEP    (slew_step),
    .TICK_DIV     (tick_div),
    .DAC_CODE_OUT (code),
    .BUSY         (busy),
    .DONE         (done),
    .CLAMPED      (clamped)
  );

  typedef struct {
    bit is_done;
    int code;
    bit clamped;
    int gap;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic exp_code(int c, int g);
    ev_t e;
    e.is_done = 1'b0;
    e.code    = c;
    e.clamped = 1'b0;
    e.gap     = g;
    exp_q.push_back(e);
  endtask

  task automatic exp_done(int c, bit cl, int g);
    ev_t e;
    e.is_done = 1'b1;
    e.code    = c;
    e.clamped = cl;
    e.gap     = g;
    exp_q.push_back(e);
  endtask

  task automatic log_event(bit d, int c, bit cl, int g);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event done=%0d code=%0d gap=%0d",
               d, c, g);
    end else begin
      e = exp_q.pop_front();
      if (e.is_done != d || e.code != c || e.gap != g ||
          (d && e.clamped != cl)) begin
        failures++;
        $display("FAIL event actual done=%0d code=%0d clamped=%0d gap=%0d required done=%0d code=%0d clamped=%0d gap=%0d",
                 d, c, cl, g, e.is_done, e.code, e.clamped, e.gap);
      end
    end
  endtask

  // Monitor: gaps are counted in edges from the accepting edge.
  int          acc_t = 0;
  bit          rst_pend = 1'b1;
  logic [13:0] prev_code = '0;

  always @(negedge clk) begin
    if (rst_pend) begin
      prev_code = code;
    end else begin
      if (code != prev_code) begin
        log_event(1'b0, int'(code), 1'b0, cyc - acc_t);
        prev_code = code;
      end
      if (done) log_event(1'b1, int'(code), clamped, cyc - acc_t);
    end
    if (sp.IN_VALID && sp.IN_READY && !rst) acc_t = cyc + 1;
    rst_pend = rst;
  end

  task automatic send(logic [63:0] v, int step, int div);
    bit ok;
    ok = 1'b0;
    sp.ADC_VOLTAGE_IN = v;
    sp.IN_VALID = 1'b1;
    slew_step = 14'(step);
    tick_div = 16'(div);
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (sp.IN_READY) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    sp.IN_VALID = 1'b0;
    slew_step = 14'd3;
    tick_div = 16'd7;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (sp.IN_READY) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  task automatic check_reset_state(string tag);
    check({tag, "_code"}, int'(code), 8191);
    check({tag, "_ready"}, int'(sp.IN_READY), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_clamped"}, int'(clamped), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    sp.ADC_VOLTAGE_IN = '0;
    sp.IN_VALID = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1;

    // Jump mode
    exp_code(12287, 4);
    exp_done(12287, 1'b0, 5);
    send(V_P5, 0, 0);
    wait_idle();

    // Slew, tick every cycle
    exp_code(8191, 4);
    exp_code(4095, 5);
    exp_done(4095, 1'b0, 6);
    send(V_M5, 4096, 0);
    wait_idle();

    // Slew, tick every 4 cycles
    exp_code(12287, 4);
    exp_done(12287, 1'b0, 5);
    send(V_P5, 0, 0);
    wait_idle();
    exp_code(8191, 7);
    exp_code(4095, 11);
    exp_done(4095, 1'b0, 12);
    send(V_M5, 4096, 3);
    wait_idle();

    // Clamping and clear on next accept
    exp_code(16383, 4);
    exp_done(16383, 1'b1, 5);
    send(V_P11, 0, 0);
    wait_idle();
    exp_code(0, 4);
    exp_done(0, 1'b1, 5);
    send(V_M12, 0, 0);
    wait_idle();
    exp_code(8191, 4);
    exp_done(8191, 1'b0, 5);
    send(V_0, 0, 0);
    wait_idle();

    // Target equals current code
    exp_done(8191, 1'b0, 4);
    send(V_0, 0, 0);
    wait_idle();

    // Held request during a ramp
    exp_code(9191, 4);
    exp_code(10191, 5);
    exp_code(11191, 6);
    exp_code(12191, 7);
    exp_code(12287, 8);
    exp_done(12287, 1'b0, 9);
    exp_code(4095, 4);
    exp_done(4095, 1'b0, 5);
    send(V_P5, 1000, 0);
    send(V_M5, 0, 0);
    wait_idle();

    // Reset mid-ramp
    exp_code(4096, 4);
    exp_code(4097, 5);
    send(V_P5, 1, 0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("midramp_reset");
    repeat (20) @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
